// File: rtl/forward_scoreboard.sv
// Register-forwarding and interlock unit: a shifting scoreboard of in-flight writes,
// checked by NUM_RD read ports. Each port gets the youngest matching result or a stall.

module forward_port #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic                            forwardMode,
    input  logic                            readEn,
    input  logic [ADDR_W-1:0]               readAddr,
    input  logic [DEPTH-1:0]                entV,
    input  logic [DEPTH-1:0]                entRdy,
    input  logic [DEPTH-1:0][ADDR_W-1:0]    entAddr,
    input  logic [DEPTH-1:0][DATA_W-1:0]    entData,
    input  logic                            lateValid,
    input  logic [DATA_W-1:0]               lateData,
    output logic                            fwdEn,
    output logic [DATA_W-1:0]               fwdData,
    output logic                            portStall
);
    logic              hit;
    logic              effRdy;
    logic [DATA_W-1:0] effData;

    always_comb begin
        hit     = 1'b0;
        effRdy  = 1'b0;
        effData = '0;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (readEn && entV[k] && (entAddr[k] == readAddr)) begin
                hit     = 1'b1;
                effRdy  = entRdy[k] || ((k == LATE_STAGE) && lateValid);
                effData = ((k == LATE_STAGE) && lateValid && !entRdy[k]) ? lateData : entData[k];
            end
        end
        fwdEn     = 1'b0;
        fwdData   = '0;
        portStall = 1'b0;
        if (forwardMode) begin
            if (hit && effRdy) begin
                fwdEn   = 1'b1;
                fwdData = effData;
            end else begin
                portStall = hit;
            end
        end else begin
            portStall = hit;
        end
    end
endmodule

module forward_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int NUM_RD     = 2,
    parameter int DEPTH      = 3,
    parameter int LATE_STAGE = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       ForwardMode,
    input  logic                       Advance,
    input  logic                       Flush,
    input  logic                       IssueValid,
    input  logic [ADDR_W-1:0]          IssueAddr,
    input  logic                       IssueDataValid,
    input  logic [DATA_W-1:0]          IssueData,
    input  logic                       LateValid,
    input  logic [DATA_W-1:0]          LateData,
    input  logic [NUM_RD-1:0]          ReadEn,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadAddr,
    output logic [NUM_RD-1:0]          ForwardEn,
    output logic [NUM_RD*DATA_W-1:0]   ForwardData,
    output logic                       Stall,
    output logic [15:0]                StallCount
);
    logic [DEPTH-1:0]                entV;
    logic [DEPTH-1:0]                entRdy;
    logic [DEPTH-1:0][ADDR_W-1:0]    entAddr;
    logic [DEPTH-1:0][DATA_W-1:0]    entData;
    logic [DEPTH-1:0]                updRdy;
    logic [DEPTH-1:0][DATA_W-1:0]    updData;

    logic [NUM_RD-1:0][ADDR_W-1:0]   rdAddr;
    logic [NUM_RD-1:0][DATA_W-1:0]   fwdData;
    logic [NUM_RD-1:0]               portStall;

    assign rdAddr      = ReadAddr;
    assign ForwardData = fwdData;
    assign Stall       = |portStall;

    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
        forward_port #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATE_STAGE(LATE_STAGE)
        ) uPort (
            .forwardMode (ForwardMode),
            .readEn      (ReadEn[p]),
            .readAddr    (rdAddr[p]),
            .entV        (entV),
            .entRdy      (entRdy),
            .entAddr     (entAddr),
            .entData     (entData),
            .lateValid   (LateValid),
            .lateData    (LateData),
            .fwdEn       (ForwardEn[p]),
            .fwdData     (fwdData[p]),
            .portStall   (portStall[p])
        );
    end

    // Late data only lands on a live, still-pending entry.
    always_comb begin
        updRdy  = entRdy;
        updData = entData;
        if (LateValid && entV[LATE_STAGE] && !entRdy[LATE_STAGE]) begin
            updRdy[LATE_STAGE]  = 1'b1;
            updData[LATE_STAGE] = LateData;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            entV       <= '0;
            entRdy     <= '0;
            entAddr    <= '0;
            entData    <= '0;
            StallCount <= '0;
        end else begin
            if (Flush) begin
                entV <= '0;
            end else if (Advance) begin
                for (int k = DEPTH - 1; k >= 1; k--) begin
                    entV[k]    <= entV[k-1];
                    entAddr[k] <= entAddr[k-1];
                    entRdy[k]  <= updRdy[k-1];
                    entData[k] <= updData[k-1];
                end
                entV[0]    <= IssueValid && !Stall;
                entAddr[0] <= IssueAddr;
                entRdy[0]  <= IssueDataValid;
                entData[0] <= IssueDataValid ? IssueData : '0;
            end else begin
                entRdy  <= updRdy;
                entData <= updData;
            end
            if (Stall && (StallCount != 16'hFFFF))
                StallCount <= StallCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed-vector bench for forward_scoreboard with hand-computed expectations.

module tb_forward_scoreboard;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int NUM_RD = 2;

    logic                      CLK = 1'b0;
    logic                      RST_N;
    logic                      ForwardMode;
    logic                      Advance;
    logic                      Flush;
    logic                      IssueValid;
    logic [ADDR_W-1:0]         IssueAddr;
    logic                      IssueDataValid;
    logic [DATA_W-1:0]         IssueData;
    logic                      LateValid;
    logic [DATA_W-1:0]         LateData;
    logic [NUM_RD-1:0]         ReadEn;
    logic [NUM_RD*ADDR_W-1:0]  ReadAddr;
    logic [NUM_RD-1:0]         ForwardEn;
    logic [NUM_RD*DATA_W-1:0]  ForwardData;
    logic                      Stall;
    logic [15:0]               StallCount;

    int nVec = 0;
    int nMis = 0;

    forward_scoreboard #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .DEPTH(3), .LATE_STAGE(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .ForwardMode(ForwardMode), .Advance(Advance), .Flush(Flush),
        .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueDataValid(IssueDataValid),
        .IssueData(IssueData), .LateValid(LateValid), .LateData(LateData), .ReadEn(ReadEn),
        .ReadAddr(ReadAddr), .ForwardEn(ForwardEn), .ForwardData(ForwardData), .Stall(Stall),
        .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Advance = 0; Flush = 0; IssueValid = 0; IssueAddr = 0; IssueDataValid = 0;
        IssueData = 0; LateValid = 0; LateData = 0; ReadEn = 0; ReadAddr = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic dv, input logic [DATA_W-1:0] d);
        IssueValid = 1; IssueAddr = a; IssueDataValid = dv; IssueData = d; Advance = 1;
    endtask

    task automatic rd(input logic [1:0] en, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        ReadEn = en; ReadAddr = {a1, a0};
    endtask

    initial begin
        // Reset with arbitrary inputs
        RST_N = 0; ForwardMode = 1; idle();
        ReadEn = 2'b11; ReadAddr = 10'($urandom); LateValid = 1; LateData = 8'($urandom);
        IssueValid = 1; Advance = 1; IssueDataValid = 1; IssueData = 8'h77;
        repeat (2) tick();
        chk("rst_fe", ForwardEn, 0);
        chk("rst_fd", ForwardData, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_cnt", StallCount, 0);
        idle(); RST_N = 1;
        tick();
        rd(2'b11, 5'd3, 5'd4); #1;
        chk("post_rst_fe", ForwardEn, 0);
        chk("post_rst_stall", Stall, 0);

        // ALU bypass
        idle(); issue(5'd3, 1, 8'h5A); tick();
        idle(); rd(2'b11, 5'd3, 5'd4); #1;
        chk("alu_fe", ForwardEn, 2'b01);
        chk("alu_fd", ForwardData, 16'h005A);
        chk("alu_stall", Stall, 0);
        rd(2'b01, 5'd3, 5'd3); #1;
        chk("alu_rden0", ForwardEn, 2'b01);

        // Youngest wins; port 1 hits the oldest entry
        idle(); issue(5'd7, 1, 8'h11); tick();
        idle(); issue(5'd7, 1, 8'h22); tick();
        idle(); rd(2'b11, 5'd7, 5'd3); #1;
        chk("young_fe", ForwardEn, 2'b11);
        chk("young_fd", ForwardData, 16'h5A22);

        // Load-use: r2 pending at entry 0 stalls, same-cycle issue becomes a bubble
        idle(); issue(5'd2, 0, 8'hEE); tick();
        idle(); rd(2'b01, 5'd2, 5'd0); issue(5'd9, 1, 8'h33); #1;
        chk("ld_stall", Stall, 1);
        chk("ld_fe", ForwardEn, 0);
        chk("ld_fd", ForwardData, 0);
        tick();
        idle(); rd(2'b11, 5'd2, 5'd9); #1;
        chk("ld_cnt", StallCount, 1);
        chk("ld_bubble_stall", Stall, 1);
        LateValid = 1; LateData = 8'h9C; #1;
        chk("late_stall", Stall, 0);
        chk("late_fe", ForwardEn, 2'b01);
        chk("late_fd", ForwardData, 16'h009C);
        tick();
        LateValid = 1; LateData = 8'h01; #1;
        chk("late_captured", ForwardData, 16'h009C);
        chk("late_cnt", StallCount, 1);

        // Flush with Advance and issue clears everything
        idle(); Flush = 1; issue(5'd5, 1, 8'h44); tick();
        idle(); rd(2'b11, 5'd5, 5'd2); #1;
        chk("flush_fe", ForwardEn, 0);
        chk("flush_stall", Stall, 0);

        // Interlock mode: any in-flight match stalls until retirement
        ForwardMode = 0;
        idle(); issue(5'd5, 1, 8'h44); tick();
        idle(); rd(2'b01, 5'd5, 5'd0); #1;
        chk("il_stall", Stall, 1);
        chk("il_fe", ForwardEn, 0);
        chk("il_fd", ForwardData, 0);
        Advance = 1;
        repeat (2) tick();
        chk("il_stall_e2", Stall, 1);
        tick();
        chk("il_retired", Stall, 0);
        chk("il_cnt", StallCount, 4);

        // Saturation
        idle(); issue(5'd5, 1, 8'h44); tick();
        idle(); rd(2'b01, 5'd5, 5'd0);
        repeat (70000) @(posedge CLK);
        #1;
        chk("sat_cnt", StallCount, 16'hFFFF);
        repeat (3) tick();
        chk("sat_nowrap", StallCount, 16'hFFFF);

        // Mid-operation reset clears state at once
        #2 RST_N = 0; #1;
        chk("mid_rst_stall", Stall, 0);
        chk("mid_rst_cnt", StallCount, 0);
        tick();
        RST_N = 1; ForwardMode = 1; tick();
        chk("mid_rst_after", Stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
